// File: rtl/seq_detect_moore_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_moore_param
//  Description : Parametrised Moore serial-pattern detector. The state is the
//                length of the matched pattern prefix (0..PAT_W). PAT_W means
//                DETECT. Mismatches fall back KMP-style, using a transition
//                table built at elaboration from PATTERN. Overlapping or
//                non-overlapping restart is chosen at run time. Includes a
//                bit-valid qualifier and a saturating match counter with
//                synchronous clear.
//  Option      : define SEQ_DET_STICKY_EN to add the det_sticky output
//                (set on every match, cleared by cnt_clr).
//  Parameters  : PAT_W   - pattern length, 2..16
//                PATTERN - pattern value, MSB is received first
//                CNT_W   - match counter width, >= 1
//  Ports       : clk        in   rising-edge clock
//                rst        in   synchronous active-low reset
//                en         in   bit valid; `in` consumed only when high
//                in         in   serial data bit
//                overlap    in   1 = overlapping, 0 = non-overlapping
//                cnt_clr    in   synchronous clear of match_cnt (and sticky)
//                dout       out  high while in DETECT
//                match_cnt  out  saturating count of detections
//                det_sticky out  sticky match flag (SEQ_DET_STICKY_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_moore_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
`ifdef SEQ_DET_STICKY_EN
    ,
    output logic             det_sticky
`endif
);

    generate
        if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
            $error("seq_detect_moore_param: PAT_W must be in 2..16");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("seq_detect_moore_param: CNT_W must be at least 1");
        end
    endgenerate

    localparam int c_SW      = $clog2(PAT_W + 1);
    localparam int c_ENTRIES = 4 << c_SW;           // indexed by {overlap, in, state}
    localparam logic [c_SW-1:0]  c_DETECT  = c_SW'(PAT_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef logic [c_ENTRIES*c_SW-1:0] tbl_t;

    // Next prefix length after the first k pattern bits have been seen and
    // bit b arrives: the longest pattern prefix that is a suffix of that string.
    function automatic int f_delta(input int k, input int b);
        int p;
        int r;
        int best;
        p    = int'(PATTERN);
        r    = ((p >> (PAT_W - k)) << 1) | b;
        best = 0;
        for (int len = 1; len <= k + 1; len++) begin
            if ((r & ((1 << len) - 1)) == (p >> (PAT_W - len)))
                best = len;
        end
        return best;
    endfunction

    // Longest proper border of PATTERN; the overlapping restart point.
    function automatic int f_border();
        int p;
        int f;
        p = int'(PATTERN);
        f = 0;
        for (int len = 1; len < PAT_W; len++) begin
            if ((p & ((1 << len) - 1)) == (p >> (PAT_W - len)))
                f = len;
        end
        return f;
    endfunction

    // Full transition table. Leaving DETECT restarts from the border
    // (overlap=1) or from the empty prefix (overlap=0); all other states
    // ignore overlap. Codes above PAT_W are unreachable and map to 0.
    function automatic tbl_t f_build();
        tbl_t t;
        int   nxt;
        int   e;
        t = '0;
        for (int ov = 0; ov < 2; ov++) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k <= PAT_W; k++) begin
                    if (k < PAT_W)
                        nxt = f_delta(k, b);
                    else if (ov == 1)
                        nxt = f_delta(f_border(), b);
                    else
                        nxt = f_delta(0, b);
                    e = ((ov * 2 + b) << c_SW) + k;
                    t = t | (tbl_t'(nxt) << (e * c_SW));
                end
            end
        end
        return t;
    endfunction

    localparam tbl_t c_TBL = f_build();

    logic [c_SW-1:0]   w_tbl [c_ENTRIES];
    logic [c_SW+1:0]   w_idx;
    logic [c_SW-1:0]   w_next;
    logic              w_hit;

    logic [c_SW-1:0]   r_state;
    logic              r_dout;
    logic [CNT_W-1:0]  r_cnt;

    generate
        for (genvar e = 0; e < c_ENTRIES; e++) begin : g_tbl
            assign w_tbl[e] = c_TBL[e*c_SW +: c_SW];
        end
    endgenerate

    assign w_idx  = {overlap, in, r_state};
    assign w_next = w_tbl[w_idx];
    assign w_hit  = en & (w_next == c_DETECT);

    // dout is registered alongside the state so it is a pure state decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= '0;
            r_dout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (en) begin
                r_state <= w_next;
                r_dout  <= (w_next == c_DETECT);
            end
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_hit && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign dout      = r_dout;
    assign match_cnt = r_cnt;

`ifdef SEQ_DET_STICKY_EN
    logic r_sticky;

    always_ff @(posedge clk) begin
        if (!rst)
            r_sticky <= 1'b0;
        else if (cnt_clr)
            r_sticky <= 1'b0;
        else if (w_hit)
            r_sticky <= 1'b1;
    end

    assign det_sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_moore_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_moore_param
//  Description : Scoreboard bench for seq_detect_moore_param. Four instances
//                with different pattern/counter parameters share one input
//                stream. A string-matching reference model pushes expected
//                outputs per edge; a monitor pops and compares on the falling
//                edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_moore_param;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic din = 1'b0;
    logic ov = 1'b0;
    logic clr = 1'b0;

    logic       dout0, dout1, dout2, dout3;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [3:0] cnt3;
    logic [3:0] stk_w;

    always #5 clk = ~clk;

    seq_detect_moore_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst_n), .en(en), .in(din), .overlap(ov), .cnt_clr(clr),
        .dout(dout0), .match_cnt(cnt0)
`ifdef SEQ_DET_STICKY_EN
        , .det_sticky(stk_w[0])
`endif
    );
    seq_detect_moore_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst_n), .en(en), .in(din), .overlap(ov), .cnt_clr(clr),
        .dout(dout1), .match_cnt(cnt1)
`ifdef SEQ_DET_STICKY_EN
        , .det_sticky(stk_w[1])
`endif
    );
    seq_detect_moore_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst_n), .en(en), .in(din), .overlap(ov), .cnt_clr(clr),
        .dout(dout2), .match_cnt(cnt2)
`ifdef SEQ_DET_STICKY_EN
        , .det_sticky(stk_w[2])
`endif
    );
    seq_detect_moore_param #(.PAT_W(6), .PATTERN(6'b101101), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst_n), .en(en), .in(din), .overlap(ov), .cnt_clr(clr),
        .dout(dout3), .match_cnt(cnt3)
`ifdef SEQ_DET_STICKY_EN
        , .det_sticky(stk_w[3])
`endif
    );

`ifndef SEQ_DET_STICKY_EN
    assign stk_w = 4'b0000;
`endif

    // ------------------------------------------------------------------
    // Reference model: keeps the raw received bit history; a detection is
    // simply "the last PAT_W received bits equal the pattern". A
    // non-overlapping restart discards the history.
    // ------------------------------------------------------------------
    int          mpw  [4] = '{4, 3, 4, 6};
    int          mpat [4] = '{13, 7, 13, 45};
    int          mcw  [4] = '{8, 8, 2, 4};
    logic [31:0] hist [4];
    int          hlen [4];
    bit          det  [4];
    int          cnt  [4];
    bit          stk  [4];

    typedef struct packed {
        logic [3:0] dout;
        logic [3:0] stk;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] c2;
        logic [3:0] c3;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;

    task automatic model_step(input bit r, input bit e, input bit b, input bit o, input bit c);
        exp_t x;
        bit   hit;
        for (int i = 0; i < 4; i++) begin
            if (!r) begin
                hist[i] = '0; hlen[i] = 0; det[i] = 0; cnt[i] = 0; stk[i] = 0;
            end else begin
                hit = 0;
                if (e) begin
                    if (det[i] && !o) begin
                        hist[i] = '0;
                        hlen[i] = 0;
                    end
                    hist[i] = {hist[i][30:0], b};
                    if (hlen[i] < 32) hlen[i]++;
                    hit = (hlen[i] >= mpw[i]) &&
                          ((int'(hist[i]) & ((1 << mpw[i]) - 1)) == mpat[i]);
                    det[i] = hit;
                end
                if (c) begin
                    cnt[i] = 0;
                    stk[i] = 0;
                end else if (hit) begin
                    if (cnt[i] < (1 << mcw[i]) - 1) cnt[i]++;
                    stk[i] = 1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            x.dout[i] = det[i];
            x.stk[i]  = stk[i];
        end
        x.c0 = 8'(cnt[0]);
        x.c1 = 8'(cnt[1]);
        x.c2 = 2'(cnt[2]);
        x.c3 = 4'(cnt[3]);
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge produces one Moore output sample.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] dv;
        if (q.size() > 0) begin
            e  = q.pop_front();
            dv = {dout3, dout2, dout1, dout0};
            for (int i = 0; i < 4; i++)
                chk($sformatf("dout[%0d]", i), 32'(dv[i]), 32'(e.dout[i]));
            chk("match_cnt[0]", 32'(cnt0), 32'(e.c0));
            chk("match_cnt[1]", 32'(cnt1), 32'(e.c1));
            chk("match_cnt[2]", 32'(cnt2), 32'(e.c2));
            chk("match_cnt[3]", 32'(cnt3), 32'(e.c3));
`ifdef SEQ_DET_STICKY_EN
            for (int i = 0; i < 4; i++)
                chk($sformatf("det_sticky[%0d]", i), 32'(stk_w[i]), 32'(e.stk[i]));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit r, input bit e, input bit b, input bit o, input bit c);
        @(negedge clk);
        rst_n = r; en = e; din = b; ov = o; clr = c;
        @(posedge clk);
        model_step(r, e, b, o, c);
    endtask

    task automatic do_reset(input bit o);
        drive(0, 0, 0, o, 0);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input bit o);
        for (int i = n - 1; i >= 0; i--)
            drive(1, 1, 1'((bits >> i) & 32'd1), o, 0);
    endtask

    // Direct constant anchor, sampled just after the edge has settled.
    task automatic anchor(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    initial begin
        // Overlapping 1101101 -> two detections
        do_reset(1);
        send_bits(32'b1101101, 7, 1);
        #1 anchor("tp1_cnt", 32'(cnt0), 32'd2);

        // Non-overlapping: same stream -> one; 11011101 -> two
        do_reset(0);
        send_bits(32'b1101101, 7, 0);
        #1 anchor("tp2_cnt", 32'(cnt0), 32'd1);
        do_reset(0);
        send_bits(32'b11011101, 8, 0);
        #1 anchor("tp2b_cnt", 32'(cnt0), 32'd2);

        // en gating with random data on idle cycles
        do_reset(1);
        for (int i = 3; i >= 0; i--) begin
            repeat ($urandom_range(0, 3)) drive(1, 0, 1'($urandom_range(0, 1)), 1, 0);
            drive(1, 1, 1'((32'b1101 >> i) & 32'd1), 1, 0);
        end
        repeat (3) drive(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        #1 anchor("tp3_dout_hold", 32'(dout0), 32'd1);
        anchor("tp3_cnt", 32'(cnt0), 32'd1);

        // 111 pattern, five ones
        do_reset(1);
        send_bits(32'b11111, 5, 1);
        #1 anchor("tp4_cnt_ov", 32'(cnt1), 32'd3);
        do_reset(0);
        send_bits(32'b11111, 5, 0);
        #1 anchor("tp4_cnt_nov", 32'(cnt1), 32'd1);

        // CNT_W=2 saturation, then clear on the 7th match
        do_reset(0);
        repeat (6) send_bits(32'b1101, 4, 0);
        #1 anchor("tp5_sat", 32'(cnt2), 32'd3);
        send_bits(32'b110, 3, 0);
        drive(1, 1, 1, 0, 1);
        #1 anchor("tp5_clr", 32'(cnt2), 32'd0);
        anchor("tp5_clr_dout", 32'(dout2), 32'd1);

        // Reset mid-pattern
        do_reset(1);
        send_bits(32'b110, 3, 1);
        do_reset(1);
        send_bits(32'b1, 1, 1);
        #1 anchor("tp6_nodet", 32'(cnt0), 32'd0);
        send_bits(32'b1101, 4, 1);
        #1 anchor("tp6_det", 32'(cnt0), 32'd1);

        // Randomised traffic
        do_reset(1);
        begin
            bit o;
            o = 1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 19) == 0) o = 1'($urandom_range(0, 1));
                drive(($urandom_range(0, 199) != 0),
                      ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)),
                      o,
                      ($urandom_range(0, 63) == 0));
            end
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected samples left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
